ifetch_unit: RTL and testbench



---
 rtl/shrv32_pkg.sv | 30 +++
 rtl/ifetch_fifo.sv | 51 +++++
 rtl/ifetch_unit.sv | 113 +++++++++++
 tb/tb_ifetch_unit.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shrv32_pkg.sv
// Shared shrv32 definitions used by the fetch stage and the decoder/controller.
package shrv32_pkg;

    localparam logic [31:0] NOP_INST         = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Major opcode field inst[6:2]
    localparam logic [4:0] OP_LOAD     = 5'b00000;
    localparam logic [4:0] OP_EXT      = 5'b00010;
    localparam logic [4:0] OP_MISC_MEM = 5'b00011;
    localparam logic [4:0] OP_IMM      = 5'b00100;
    localparam logic [4:0] OP_AUIPC    = 5'b00101;
    localparam logic [4:0] OP_STORE    = 5'b01000;
    localparam logic [4:0] OP_OP       = 5'b01100;
    localparam logic [4:0] OP_LUI      = 5'b01101;
    localparam logic [4:0] OP_BRANCH   = 5'b11000;
    localparam logic [4:0] OP_JALR     = 5'b11001;
    localparam logic [4:0] OP_JAL      = 5'b11011;
    localparam logic [4:0] OP_SYSTEM   = 5'b11100;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Instruction buffer holding {pc, word} pairs; flush clears it in one cycle.
module ifetch_fifo
    import shrv32_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  fetch_entry_t  push_data,
    input  logic          pop,
    input  logic          flush,
    output fetch_entry_t  head,
    output logic [CW-1:0] count
);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && !flush;
    assign do_pop  = pop && (count != '0) && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/ifetch_unit.sv
// shrv32 fetch stage: owns the PC, issues word fetches, buffers responses and
// presents the head instruction with pre-sliced fields to decode.
module ifetch_unit
    import shrv32_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        inst_ready,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [4:0]  opcode,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7,
    output logic [4:0]  rd,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic        inst_misfmt
);

    localparam int          CW        = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_LIM = (CW + 1)'(DEPTH);

    logic          started;
    logic [31:0]   fetch_pc;
    logic [31:0]   rsp_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] discard;
    logic [CW-1:0] count;
    logic [CW:0]   inflight;
    logic [31:0]   target;
    logic          fire;
    logic          rsp_ok;
    logic          drop;
    logic          keep;
    logic          pop;
    fetch_entry_t  push_data;
    fetch_entry_t  head;

    // Buffered words plus in-flight requests never exceed DEPTH, so a kept
    // response always has a free slot.
    assign inflight  = {1'b0, count} + {1'b0, outstanding};
    assign imem_req  = started && !redirect_valid && (inflight < DEPTH_LIM);
    assign imem_addr = fetch_pc;
    assign target    = word_align(redirect_pc);

    assign fire   = imem_req && imem_gnt;
    assign rsp_ok = imem_rvalid && (outstanding != '0);
    assign drop   = rsp_ok && (discard != '0);
    assign keep   = rsp_ok && (discard == '0) && !redirect_valid;
    assign pop    = inst_valid && inst_ready && !redirect_valid;

    assign push_data = '{pc: rsp_pc, word: imem_rdata};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            started     <= 1'b0;
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            started <= 1'b1;
            if (redirect_valid) begin
                // Everything still in flight belongs to the old path.
                fetch_pc    <= target;
                rsp_pc      <= target;
                outstanding <= outstanding - CW'(rsp_ok);
                discard     <= outstanding - CW'(rsp_ok);
            end else begin
                if (fire) fetch_pc <= fetch_pc + 32'd4;
                if (keep) rsp_pc <= rsp_pc + 32'd4;
                outstanding <= outstanding + CW'(fire) - CW'(rsp_ok);
                if (drop) discard <= discard - CW'(1);
            end
        end
    end

    ifetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (keep),
        .push_data(push_data),
        .pop      (pop),
        .flush    (redirect_valid),
        .head     (head),
        .count    (count)
    );

    assign inst_valid  = (count != '0);
    assign inst        = inst_valid ? head.word : NOP_INST;
    assign inst_pc     = inst_valid ? head.pc : 32'h0000_0000;
    assign opcode      = inst[6:2];
    assign funct3      = inst[14:12];
    assign funct7      = inst[31:25];
    assign rd          = inst[11:7];
    assign rs1         = inst[19:15];
    assign rs2         = inst[24:20];
    assign inst_misfmt = inst_valid && (inst[1:0] != 2'b11);

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: behavioural memory with configurable grant delay and
// response latency, and an in-order scoreboard of expected {pc, word}.
module tb_ifetch_unit;
    import shrv32_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam int          DEPTH  = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        inst_ready = 1'b0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [4:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        inst_misfmt;
    logic [31:0] dut_fields;

    always #5 clk = ~clk;

    ifetch_unit #(
        .RESET_PC(RST_PC),
        .DEPTH   (DEPTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .inst_ready    (inst_ready),
        .inst_valid    (inst_valid),
        .inst          (inst),
        .inst_pc       (inst_pc),
        .opcode        (opcode),
        .funct3        (funct3),
        .funct7        (funct7),
        .rd            (rd),
        .rs1           (rs1),
        .rs2           (rs2),
        .inst_misfmt   (inst_misfmt)
    );

    assign dut_fields = {1'b0, opcode, funct3, funct7, rd, rs1, rs2, inst_misfmt};

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    function automatic logic [31:0] exp_fields(input logic [31:0] w, input bit v);
        return {1'b0, w[6:2], w[14:12], w[31:25], w[11:7], w[19:15], w[24:20],
                v && (w[1:0] != 2'b11)};
    endfunction

    // Memory model configuration
    int gnt_dly = 0;
    int lat = 1;
    int mode = 0;

    function automatic logic [31:0] memword(input logic [31:0] a);
        case (mode)
            0:       return a;
            1:       return {~a[31:2], 2'b11};
            default: return 32'h0000_0000;
        endcase
    endfunction

    typedef struct {
        int          due;
        logic [31:0] data;
    } rsp_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;

    rsp_t        rq[$];
    exp_t        sb[$];
    int          cyc = 0;
    int          last_due = 0;
    int          wcnt = 0;
    bit          waiting = 0;
    logic [31:0] wait_addr = 32'h0;
    int          grants = 0;
    int          mdl_out = 0;
    int          consumed = 0;
    logic [31:0] last_pc = 32'h0;
    logic [31:0] exp_fetch = RST_PC;

    always @(posedge clk) cyc++;

    // Memory + scoreboard, evaluated mid-cycle when all inputs are settled.
    always @(negedge clk) begin
        if (!rst_n) begin
            rq.delete();
            sb.delete();
            exp_fetch   = RST_PC;
            wcnt        = 0;
            waiting     = 0;
            last_due    = 0;
            mdl_out     = 0;
            consumed    = 0;
            imem_gnt    = 1'b0;
            imem_rvalid = 1'b0;
        end else begin
            if (rq.size() > 0 && rq[0].due <= cyc) begin
                assert (mdl_out > 0) else $error("rvalid with nothing outstanding");
                imem_rvalid = 1'b1;
                imem_rdata  = rq[0].data;
                void'(rq.pop_front());
                mdl_out--;
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = 32'hDEAD_BEEF;
            end

            imem_gnt = imem_req && (wcnt >= gnt_dly);
            if (imem_req) begin
                if (waiting) chk("addr_stable", imem_addr, wait_addr);
                if (imem_gnt) begin
                    int due;
                    chk("fetch_addr", imem_addr, exp_fetch);
                    due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
                    rq.push_back('{due, memword(imem_addr)});
                    last_due = due;
                    sb.push_back('{exp_fetch, memword(exp_fetch)});
                    exp_fetch = exp_fetch + 32'd4;
                    wcnt    = 0;
                    waiting = 0;
                    grants++;
                    mdl_out++;
                end else begin
                    wcnt++;
                    waiting   = 1;
                    wait_addr = imem_addr;
                end
            end else begin
                wcnt    = 0;
                waiting = 0;
            end

            if (redirect_valid) begin
                chk("redirect_no_req", imem_req, 1'b0);
                sb.delete();
                exp_fetch = {redirect_pc[31:2], 2'b00};
                consumed  = 0;
            end else if (inst_valid && inst_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", inst_pc, 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("inst_pc", inst_pc, e.pc);
                    chk("inst", inst, e.word);
                    chk("fields", dut_fields, exp_fields(e.word, 1'b1));
                    consumed++;
                    last_pc = e.pc;
                end
            end

            if (!inst_valid) begin
                chk("idle_inst", inst, NOP_INST);
                chk("idle_pc", inst_pc, 32'h0);
                chk("idle_misfmt", inst_misfmt, 1'b0);
            end
        end
    end

    task automatic redirect_to(input logic [31:0] pc);
        @(posedge clk);
        #1 redirect_valid = 1'b1;
        redirect_pc = pc;
        @(posedge clk);
        #1 redirect_valid = 1'b0;
    endtask

    task automatic wait_consumed(input int n, input string name, input logic [31:0] want_last,
                                 input bit rnd);
        int k = 0;
        while (consumed < n && k < 400) begin
            @(posedge clk);
            #1 k++;
            if (rnd) inst_ready = 1'($urandom_range(0, 1));
        end
        chk({name, "_done"}, 32'(consumed >= n), 32'd1);
        chk({name, "_last_pc"}, last_pc, want_last);
        inst_ready = 1'b1;
    endtask

    typedef struct {
        logic [31:0] start;
        int          gdly;
        int          lt;
        int          md;
        bit          rnd;
        int          n;
        logic [31:0] last;
    } row_t;

    row_t rows[6];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g0;
        bit hit;

        rows[0] = '{32'h0000_1000, 0, 1, 1, 1'b0, 8, 32'h0000_101C};
        rows[1] = '{32'h0000_2000, 3, 4, 1, 1'b0, 5, 32'h0000_2010};
        rows[2] = '{32'h0000_3000, 1, 2, 1, 1'b1, 10, 32'h0000_3024};
        rows[3] = '{32'hFFFF_FFF8, 0, 1, 1, 1'b0, 4, 32'h0000_0004};
        rows[4] = '{32'h0000_4000, 0, 1, 2, 1'b0, 3, 32'h0000_4008};
        rows[5] = '{32'h0000_5001, 2, 3, 0, 1'b1, 6, 32'h0000_5014};

        // Reset state
        repeat (2) @(posedge clk);
        #3;
        chk("rst_req", imem_req, 1'b0);
        chk("rst_valid", inst_valid, 1'b0);
        chk("rst_inst", inst, NOP_INST);
        chk("rst_pc", inst_pc, 32'h0);
        chk("rst_fields", dut_fields, exp_fields(NOP_INST, 1'b0));

        // First fetch latency after reset release
        @(posedge clk);
        #1 rst_n = 1'b1;
        inst_ready = 1'b1;
        #2 chk("req_in_release_cycle", imem_req, 1'b0);
        @(posedge clk);
        #3 chk("first_req", imem_req, 1'b1);
        chk("first_addr", imem_addr, RST_PC);
        @(posedge clk);
        #3 chk("lat_not_yet", inst_valid, 1'b0);
        @(posedge clk);
        #3 chk("lat_valid", inst_valid, 1'b1);
        chk("lat_pc", inst_pc, RST_PC);
        wait_consumed(8, "seq", 32'h0000_011C, 1'b0);

        // Decode stall: buffer fills to DEPTH and fetching stops
        inst_ready = 1'b0;
        redirect_to(32'h0000_0300);
        g0 = grants;
        repeat (8) @(posedge clk);
        #3 chk("stall_grants", 32'(grants - g0), 32'(DEPTH));
        chk("stall_req", imem_req, 1'b0);
        chk("stall_head", inst_pc, 32'h0000_0300);
        inst_ready = 1'b1;
        wait_consumed(6, "drain", 32'h0000_0314, 1'b0);

        // Redirect with two requests in flight
        inst_ready = 1'b0;
        lat = 3;
        redirect_to(32'h0000_0400);
        @(posedge clk);
        @(posedge clk);
        #1 redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0203;
        @(posedge clk);
        #1 redirect_valid = 1'b0;
        #2 chk("rd_req", imem_req, 1'b1);
        chk("rd_addr", imem_addr, 32'h0000_0200);
        inst_ready = 1'b1;
        for (int k = 0; k < 20 && !inst_valid; k++) begin
            @(posedge clk);
            #3;
        end
        chk("rd_first_pc", inst_pc, 32'h0000_0200);
        wait_consumed(4, "rd", 32'h0000_020C, 1'b0);

        // Redirect coinciding with a response and a pop
        lat = 2;
        redirect_to(32'h0000_0500);
        hit = 0;
        for (int k = 0; k < 30 && !hit; k++) begin
            @(posedge clk);
            #1;
            if (rq.size() > 0 && rq[0].due <= cyc && inst_valid) begin
                redirect_valid = 1'b1;
                redirect_pc = 32'h0000_0600;
                hit = 1;
            end
        end
        chk("same_hit", 32'(hit), 32'd1);
        @(posedge clk);
        #1 redirect_valid = 1'b0;
        #2 chk("same_empty", inst_valid, 1'b0);
        chk("same_req", imem_req, 1'b1);
        chk("same_addr", imem_addr, 32'h0000_0600);
        wait_consumed(5, "same", 32'h0000_0610, 1'b0);

        // Back-to-back redirects: the last one wins
        lat = 1;
        @(posedge clk);
        #1 redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0700;
        @(posedge clk);
        #1 redirect_pc = 32'h0000_0800;
        @(posedge clk);
        #1 redirect_valid = 1'b0;
        wait_consumed(3, "b2b", 32'h0000_0808, 1'b0);

        // Table of fetch scenarios
        for (int i = 0; i < 6; i++) begin
            gnt_dly = rows[i].gdly;
            lat     = rows[i].lt;
            mode    = rows[i].md;
            inst_ready = 1'b1;
            redirect_to(rows[i].start);
            wait_consumed(rows[i].n, $sformatf("row%0d", i), rows[i].last, rows[i].rnd);
        end

        // Reset in the middle of traffic
        gnt_dly = 0;
        lat = 2;
        mode = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 chk("midrst_req", imem_req, 1'b0);
        chk("midrst_valid", inst_valid, 1'b0);
        chk("midrst_inst", inst, NOP_INST);
        @(posedge clk);
        #1 rst_n = 1'b1;
        wait_consumed(3, "post_rst", 32'h0000_0108, 1'b0);

        repeat (4) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
